frame_scaler_pipe: RTL and testbench
====================================

# frame_scaler_pipe

Parametrised, pipelined successor to the fixed 2x frame scaler. It maps a SRC_W x SRC_H 12-bit RGB frame buffer onto a DISP_W x DISP_H VGA raster at a runtime-selectable 1x or 2x integer scale, centred, with a programmable border colour. Addresses are generated incrementally (no multiplier), and frame-buffer read latency is absorbed by a matched delay pipeline. The block sits between the VGA timing generator and the display frame-buffer read port, and supplies a per-frame base address and a frame-done pulse for double buffering.

## Interface
- SRC_W, 320, source frame width in pixels
- SRC_H, 240, source frame height in pixels
- DISP_W, 800, raster width; pixel_x runs 0..DISP_W-1
- DISP_H, 600, raster height; pixel_y runs 0..DISP_H-1
- ADDR_W, 17, frame-buffer address width (`DISP_ADDR_WIDTH`)
- RD_LAT, 1, frame-buffer read latency in cycles (1..4)

- clk  in  1  system clock; one raster pixel per cycle
- reset  in  1  synchronous, active-high reset
- pixel_x  in  10  current raster X
- pixel_y  in  10  current raster Y
- scale_sel  in  1  0 = 1x, 1 = 2x; sampled at frame start
- fb_base  in  ADDR_W  buffer base address; sampled at frame start
- border_rgb  in  12  padding colour {R,G,B}; sampled at frame start
- fb_read_addr  out  ADDR_W  registered frame-buffer read address
- fb_read_data  in  12  read data, valid RD_LAT cycles after address
- color_r / color_g / color_b  out  4 each  registered RGB output
- frame_done  out  1  one-cycle pulse after the last source pixel is addressed

## Operation
- Frame start (FS) is pixel_x==0 && pixel_y==0. On FS, latch scale_sel, fb_base and border_rgb into shadow registers. Use only the shadow values for the whole frame.
- Derived from shadow scale S (1 or 2):
  - H_OFF = (DISP_W - S*SRC_W)/2
  - V_OFF = (DISP_H - S*SRC_H)/2
  - Defaults give 1x: 240/180; 2x: 80/60.
- in_area = H_OFF <= pixel_x < H_OFF + S*SRC_W, and V_OFF <= pixel_y < V_OFF + S*SRC_H.
- Counters (11-bit x_sub/y_sub, src_x 9-bit, row_base ADDR_W):
  - On FS: clear src_x, x_sub, y_sub and row_base.
  - While in_area, each cycle: x_sub increments. When x_sub == S-1, x_sub clears and src_x increments.
  - At the last in_area pixel of a row (src_x == SRC_W-1 && x_sub == S-1):
    - Clear src_x.
    - y_sub increments. When y_sub == S-1, y_sub clears and row_base += SRC_W.
- Address: fb_read_addr <= in_area ? shadow_base + row_base + src_x : 0. Sums wrap modulo 2^ADDR_W.
- frame_done asserts for one cycle, in the cycle after the last area pixel (src_x==SRC_W-1, last row, x_sub==S-1, y_sub==S-1) is addressed.
- Colour: in_area is delayed by 1+RD_LAT stages. If the delayed flag is set, output fb_read_data; otherwise output shadow border_rgb.
  - The border value is delayed the same depth, so a colour change takes effect cleanly at the frame boundary.
- scale_sel or fb_base changing mid-frame has no effect until the next FS.
- Reset mid-frame:
  - Outputs return to zero and the pipeline is flushed.
  - Shadow registers reset to scale 2x, base 0, border 12'hFFE.
  - Output stays border/black until the next FS re-synchronises the counters.
  - Outputs are not valid picture data before the first FS after reset.

## Timing
- Reset values:
  - fb_read_addr = 0; color_r/g/b = 0; frame_done = 0.
  - All pipeline valid flags are 0; counters are 0.
- Address latency: pixel (x,y) on inputs at cycle N → fb_read_addr at cycle N+1.
- Colour latency: pixel at cycle N → color_* at cycle N+2+RD_LAT (default N+3). The timing generator delays sync by the same amount.
- No stalls or backpressure; the pipeline advances every cycle.
- FS latch and counter clear happen in the same cycle. The first area pixel of the frame always reads shadow_base + 0.

## Test plan
- Reset: hold reset 3 cycles mid-frame → all outputs 0, frame_done 0. After the next FS, the first area pixel addresses fb_base.
- 2x default, fb_base=0, border default:
  - (80,60) and (81,60) both → addr 0.
  - (82,61) → addr 1.
  - (80,62) → addr 320.
  - (719,539) → addr 76799.
  - (79,60) → colour F,F,E.
- 1x, fb_base=0: (240,180) → addr 0; (241,180) → addr 1; (240,181) → addr 320; (559,419) → addr 76799; (560,180) → border.
- Latency: RD_LAT=2, memory model returns addr[11:0] as data → color at cycle N+4 equals the addressed pixel's value.
- Double buffer: fb_base changed 0→16'h8000 mid-frame → the current frame keeps base 0. The next frame's first pixel addresses 16'h8000, and frame_done pulses exactly once per frame.
- Mid-frame scale_sel toggle 1→0 → 2x geometry holds until the next FS, then 1x offsets 240/180 apply.

Source files
------------

// File: rtl/frame_scaler_pipe_if.sv
// Raster-to-frame-buffer bundle for frame_scaler_pipe.
// Latency: none (signal bundle only).
// Backpressure: none; every signal is sampled every cycle.
// Ports: pixel_x/pixel_y raster position, scale_sel/fb_base/border_rgb frame
// settings, fb_read_addr/fb_read_data buffer port, color_r/g/b and frame_done.
interface frame_scaler_pipe_if #(
    parameter int ADDR_W = 17
);
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              scale_sel;
    logic [ADDR_W-1:0] fb_base;
    logic [11:0]       border_rgb;
    logic [ADDR_W-1:0] fb_read_addr;
    logic [11:0]       fb_read_data;
    logic [3:0]        color_r;
    logic [3:0]        color_g;
    logic [3:0]        color_b;
    logic              frame_done;

    // Timing generator plus frame-buffer memory side.
    modport master (
        output pixel_x, pixel_y, scale_sel, fb_base, border_rgb, fb_read_data,
        input  fb_read_addr, color_r, color_g, color_b, frame_done
    );

    // Scaler side.
    modport slave (
        input  pixel_x, pixel_y, scale_sel, fb_base, border_rgb, fb_read_data,
        output fb_read_addr, color_r, color_g, color_b, frame_done
    );
endinterface

// File: rtl/frame_scaler_pipe.sv
// Centred 1x/2x frame-buffer scaler with border colour and read-latency matching.
// Latency: address 1 cycle after pixel, colour 2+RD_LAT cycles after pixel.
// Backpressure: none; the pipeline advances every cycle.
// Ports: clk, reset (sync, active-high), bus (frame_scaler_pipe_if.slave).
module frame_scaler_pipe #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int DISP_W = 800,
    parameter int DISP_H = 600,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    frame_scaler_pipe_if.slave bus
);
    localparam logic [10:0] H_OFF_1X = 11'((DISP_W - SRC_W) / 2);
    localparam logic [10:0] H_END_1X = 11'((DISP_W - SRC_W) / 2 + SRC_W);
    localparam logic [10:0] V_OFF_1X = 11'((DISP_H - SRC_H) / 2);
    localparam logic [10:0] V_END_1X = 11'((DISP_H - SRC_H) / 2 + SRC_H);
    localparam logic [10:0] H_OFF_2X = 11'((DISP_W - 2 * SRC_W) / 2);
    localparam logic [10:0] H_END_2X = 11'((DISP_W - 2 * SRC_W) / 2 + 2 * SRC_W);
    localparam logic [10:0] V_OFF_2X = 11'((DISP_H - 2 * SRC_H) / 2);
    localparam logic [10:0] V_END_2X = 11'((DISP_H - 2 * SRC_H) / 2 + 2 * SRC_H);

    localparam logic [8:0]        SRC_X_LAST = 9'(SRC_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'((SRC_H - 1) * SRC_W);

    // Per-frame shadow settings.
    logic              sh_scale;
    logic [ADDR_W-1:0] sh_base;
    logic [11:0]       sh_border;
    // Set by the first frame start after reset; no picture data before it.
    logic              synced;

    logic [10:0]       x_sub, y_sub;
    logic [8:0]        src_x;
    logic [ADDR_W-1:0] row_base;

    logic [ADDR_W-1:0] rd_addr;
    logic              done_q;
    logic [11:0]       rgb_q;
    logic [RD_LAT:0]   area_pipe;
    logic [11:0]       border_pipe [RD_LAT+1];

    // At frame start the incoming settings and cleared counters are used
    // directly, so the latch and the counter clear act in the same cycle.
    logic              fs;
    logic              eff_scale;
    logic [ADDR_W-1:0] eff_base;
    logic [11:0]       eff_border;
    logic [10:0]       x_sub_c, y_sub_c;
    logic [8:0]        src_x_c;
    logic [ADDR_W-1:0] row_base_c;

    assign fs         = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
    assign eff_scale  = fs ? bus.scale_sel  : sh_scale;
    assign eff_base   = fs ? bus.fb_base    : sh_base;
    assign eff_border = fs ? bus.border_rgb : sh_border;
    assign x_sub_c    = fs ? '0 : x_sub;
    assign y_sub_c    = fs ? '0 : y_sub;
    assign src_x_c    = fs ? '0 : src_x;
    assign row_base_c = fs ? '0 : row_base;

    logic [10:0] px, py, h_lo, h_hi, v_lo, v_hi;
    logic        in_area;

    assign px   = {1'b0, bus.pixel_x};
    assign py   = {1'b0, bus.pixel_y};
    assign h_lo = eff_scale ? H_OFF_2X : H_OFF_1X;
    assign h_hi = eff_scale ? H_END_2X : H_END_1X;
    assign v_lo = eff_scale ? V_OFF_2X : V_OFF_1X;
    assign v_hi = eff_scale ? V_END_2X : V_END_1X;

    assign in_area = (fs || synced) &&
                     (px >= h_lo) && (px < h_hi) && (py >= v_lo) && (py < v_hi);

    // Sub-pixel wrap points: S-1 is 1 in 2x mode, 0 in 1x mode.
    logic x_last, y_last, row_end, frame_last;

    assign x_last     = eff_scale ? (x_sub_c == 11'd1) : (x_sub_c == 11'd0);
    assign y_last     = eff_scale ? (y_sub_c == 11'd1) : (y_sub_c == 11'd0);
    assign row_end    = (src_x_c == SRC_X_LAST) && x_last;
    assign frame_last = in_area && row_end && y_last && (row_base_c == ROW_LAST);

    logic [10:0]       x_sub_n, y_sub_n;
    logic [8:0]        src_x_n;
    logic [ADDR_W-1:0] row_base_n;
    logic [ADDR_W-1:0] addr_n;

    always_comb begin
        x_sub_n    = x_sub_c;
        y_sub_n    = y_sub_c;
        src_x_n    = src_x_c;
        row_base_n = row_base_c;
        if (in_area) begin
            if (x_last) begin
                x_sub_n = '0;
                if (src_x_c == SRC_X_LAST) begin
                    src_x_n = '0;
                    if (y_last) begin
                        y_sub_n    = '0;
                        row_base_n = row_base_c + ROW_STEP;
                    end else begin
                        y_sub_n = y_sub_c + 11'd1;
                    end
                end else begin
                    src_x_n = src_x_c + 9'd1;
                end
            end else begin
                x_sub_n = x_sub_c + 11'd1;
            end
        end
    end

    // Incremental address; sums wrap modulo 2^ADDR_W.
    assign addr_n = eff_base + row_base_c + ADDR_W'(src_x_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_scale  <= 1'b1;
            sh_base   <= '0;
            sh_border <= 12'hFFE;
            synced    <= 1'b0;
            x_sub     <= '0;
            y_sub     <= '0;
            src_x     <= '0;
            row_base  <= '0;
            rd_addr   <= '0;
            done_q    <= 1'b0;
            rgb_q     <= '0;
            area_pipe <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                border_pipe[i] <= '0;
            end
        end else begin
            if (fs) begin
                sh_scale  <= bus.scale_sel;
                sh_base   <= bus.fb_base;
                sh_border <= bus.border_rgb;
                synced    <= 1'b1;
            end
            x_sub    <= x_sub_n;
            y_sub    <= y_sub_n;
            src_x    <= src_x_n;
            row_base <= row_base_n;
            rd_addr  <= in_area ? addr_n : '0;
            done_q   <= frame_last;

            // Stage 0 lines up with rd_addr; stage RD_LAT with fb_read_data.
            area_pipe      <= {area_pipe[RD_LAT-1:0], in_area};
            border_pipe[0] <= eff_border;
            for (int i = 1; i <= RD_LAT; i++) begin
                border_pipe[i] <= border_pipe[i-1];
            end
            rgb_q <= area_pipe[RD_LAT] ? bus.fb_read_data : border_pipe[RD_LAT];
        end
    end

    assign bus.fb_read_addr = rd_addr;
    assign bus.frame_done   = done_q;
    assign bus.color_r      = rgb_q[11:8];
    assign bus.color_g      = rgb_q[7:4];
    assign bus.color_b      = rgb_q[3:0];
endmodule

// File: tb/tb_frame_scaler_pipe.sv
// Directed bench for frame_scaler_pipe on a reduced raster (16x12 source on a
// 40x30 display, RD_LAT=2) so whole frames fit a short run.
// 2x area: x 4..35, y 3..26.  1x area: x 12..27, y 9..20.
module tb_frame_scaler_pipe;
    localparam int SW = 16;
    localparam int SH = 12;
    localparam int DW = 40;
    localparam int DH = 30;
    localparam int AW = 17;
    localparam int RL = 2;
    localparam int NPIX = DW * DH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_scaler_pipe_if #(.ADDR_W(AW)) bus ();

    frame_scaler_pipe #(
        .SRC_W(SW), .SRC_H(SH), .DISP_W(DW), .DISP_H(DH), .ADDR_W(AW), .RD_LAT(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Frame-buffer model: returns addr[11:0], two cycles after the address.
    logic [AW-1:0] rd_d1 = '0;
    logic [AW-1:0] rd_d2 = '0;
    always @(posedge clk) begin
        rd_d1 <= bus.fb_read_addr;
        rd_d2 <= rd_d1;
    end
    assign bus.fb_read_data = rd_d2[11:0];

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt;
    logic [AW-1:0] obs_addr [NPIX];
    logic [11:0]   obs_col  [NPIX];

    function automatic int idx(input int x, input int y);
        return y * DW + x;
    endfunction

    task automatic drive_px(input int x, input int y);
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        @(posedge clk);
        #1;
    endtask

    // Runs one full raster. Address of pixel k is seen one edge later; colour
    // of pixel k four edges later (2 + RD_LAT), filed back under pixel k.
    task automatic run_frame(input int mid_k, input logic mid_scale, input logic [AW-1:0] mid_base);
        done_cnt = 0;
        for (int k = 0; k < NPIX; k++) begin
            if (k == mid_k) begin
                bus.scale_sel = mid_scale;
                bus.fb_base   = mid_base;
            end
            drive_px(k % DW, k / DW);
            obs_addr[k] = bus.fb_read_addr;
            if (k >= 3) obs_col[k-3] = {bus.color_r, bus.color_g, bus.color_b};
            if (bus.frame_done === 1'b1) done_cnt++;
        end
    endtask

    task automatic test_reset();
        bus.scale_sel  = 1'b1;
        bus.fb_base    = '0;
        bus.border_rgb = 12'hFFE;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive_px(20 + i, 15);
        tests_run++; if (bus.fb_read_addr !== 17'h0) begin tests_failed++; $display("FAIL rst_addr: got %h want %h", bus.fb_read_addr, 17'h0); end
        tests_run++; if ({bus.color_r, bus.color_g, bus.color_b} !== 12'h000) begin tests_failed++; $display("FAIL rst_color: got %h want %h", {bus.color_r, bus.color_g, bus.color_b}, 12'h000); end
        tests_run++; if (bus.frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", bus.frame_done); end
        reset = 1'b0;
        // Rest of the interrupted frame: counters are not synchronised yet.
        for (int k = idx(23, 15); k < NPIX; k++) begin
            drive_px(k % DW, k / DW);
            if (k == idx(10, 20)) begin
                tests_run++; if (bus.fb_read_addr !== 17'h0) begin tests_failed++; $display("FAIL rst_presync_addr: got %h want %h", bus.fb_read_addr, 17'h0); end
            end
        end
        bus.fb_base = 17'h100;
        run_frame(-1, 1'b1, '0);
        tests_run++; if (obs_addr[idx(4, 3)] !== 17'h100) begin tests_failed++; $display("FAIL rst_first_addr: got %h want %h", obs_addr[idx(4, 3)], 17'h100); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL rst_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_scale_2x();
        bus.scale_sel  = 1'b1;
        bus.fb_base    = '0;
        bus.border_rgb = 12'hFFE;
        run_frame(-1, 1'b1, '0);
        tests_run++; if (obs_addr[idx(4, 3)] !== 17'd0) begin tests_failed++; $display("FAIL s2_addr_4_3: got %h want %h", obs_addr[idx(4, 3)], 17'd0); end
        tests_run++; if (obs_addr[idx(5, 3)] !== 17'd0) begin tests_failed++; $display("FAIL s2_addr_5_3: got %h want %h", obs_addr[idx(5, 3)], 17'd0); end
        tests_run++; if (obs_addr[idx(6, 4)] !== 17'd1) begin tests_failed++; $display("FAIL s2_addr_6_4: got %h want %h", obs_addr[idx(6, 4)], 17'd1); end
        tests_run++; if (obs_addr[idx(4, 5)] !== 17'd16) begin tests_failed++; $display("FAIL s2_addr_4_5: got %h want %h", obs_addr[idx(4, 5)], 17'd16); end
        tests_run++; if (obs_addr[idx(35, 26)] !== 17'd191) begin tests_failed++; $display("FAIL s2_addr_last: got %h want %h", obs_addr[idx(35, 26)], 17'd191); end
        tests_run++; if (obs_addr[idx(36, 3)] !== 17'd0) begin tests_failed++; $display("FAIL s2_addr_outside: got %h want %h", obs_addr[idx(36, 3)], 17'd0); end
        tests_run++; if (obs_col[idx(3, 3)] !== 12'hFFE) begin tests_failed++; $display("FAIL s2_border: got %h want %h", obs_col[idx(3, 3)], 12'hFFE); end
        tests_run++; if (obs_col[idx(6, 4)] !== 12'h001) begin tests_failed++; $display("FAIL s2_color_6_4: got %h want %h", obs_col[idx(6, 4)], 12'h001); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL s2_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_scale_1x();
        bus.scale_sel  = 1'b0;
        bus.fb_base    = '0;
        bus.border_rgb = 12'h5A3;
        run_frame(-1, 1'b0, '0);
        tests_run++; if (obs_addr[idx(12, 9)] !== 17'd0) begin tests_failed++; $display("FAIL s1_addr_12_9: got %h want %h", obs_addr[idx(12, 9)], 17'd0); end
        tests_run++; if (obs_addr[idx(13, 9)] !== 17'd1) begin tests_failed++; $display("FAIL s1_addr_13_9: got %h want %h", obs_addr[idx(13, 9)], 17'd1); end
        tests_run++; if (obs_addr[idx(12, 10)] !== 17'd16) begin tests_failed++; $display("FAIL s1_addr_12_10: got %h want %h", obs_addr[idx(12, 10)], 17'd16); end
        tests_run++; if (obs_addr[idx(27, 20)] !== 17'd191) begin tests_failed++; $display("FAIL s1_addr_last: got %h want %h", obs_addr[idx(27, 20)], 17'd191); end
        tests_run++; if (obs_addr[idx(28, 9)] !== 17'd0) begin tests_failed++; $display("FAIL s1_addr_outside: got %h want %h", obs_addr[idx(28, 9)], 17'd0); end
        tests_run++; if (obs_col[idx(28, 9)] !== 12'h5A3) begin tests_failed++; $display("FAIL s1_border: got %h want %h", obs_col[idx(28, 9)], 12'h5A3); end
        tests_run++; if (obs_col[idx(13, 10)] !== 12'h011) begin tests_failed++; $display("FAIL s1_color_13_10: got %h want %h", obs_col[idx(13, 10)], 12'h011); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL s1_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_latency();
        bus.scale_sel  = 1'b1;
        bus.fb_base    = 17'h123;
        bus.border_rgb = 12'h000;
        run_frame(-1, 1'b1, '0);
        // Neighbours hold different source pixels, so an early or late colour shows.
        tests_run++; if (obs_addr[idx(7, 7)] !== 17'h144) begin tests_failed++; $display("FAIL lat_addr_7_7: got %h want %h", obs_addr[idx(7, 7)], 17'h144); end
        tests_run++; if (obs_col[idx(7, 7)] !== 12'h144) begin tests_failed++; $display("FAIL lat_color_7_7: got %h want %h", obs_col[idx(7, 7)], 12'h144); end
        tests_run++; if (obs_col[idx(8, 7)] !== 12'h145) begin tests_failed++; $display("FAIL lat_color_8_7: got %h want %h", obs_col[idx(8, 7)], 12'h145); end
    endtask

    task automatic test_double_buffer();
        bus.scale_sel  = 1'b1;
        bus.fb_base    = '0;
        bus.border_rgb = 12'hFFE;
        run_frame(10 * DW, 1'b1, 17'h8000);
        tests_run++; if (obs_addr[idx(35, 26)] !== 17'd191) begin tests_failed++; $display("FAIL db_hold_base: got %h want %h", obs_addr[idx(35, 26)], 17'd191); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL db_done_cnt0: got %0d want 1", done_cnt); end
        run_frame(-1, 1'b1, '0);
        tests_run++; if (obs_addr[idx(4, 3)] !== 17'h8000) begin tests_failed++; $display("FAIL db_new_base: got %h want %h", obs_addr[idx(4, 3)], 17'h8000); end
        tests_run++; if (obs_addr[idx(35, 26)] !== 17'h80BF) begin tests_failed++; $display("FAIL db_new_last: got %h want %h", obs_addr[idx(35, 26)], 17'h80BF); end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL db_done_cnt1: got %0d want 1", done_cnt); end
    endtask

    task automatic test_scale_toggle();
        bus.scale_sel  = 1'b1;
        bus.fb_base    = '0;
        bus.border_rgb = 12'h0C7;
        run_frame(5 * DW, 1'b0, '0);
        tests_run++; if (obs_addr[idx(12, 9)] !== 17'd52) begin tests_failed++; $display("FAIL tg_hold_12_9: got %h want %h", obs_addr[idx(12, 9)], 17'd52); end
        tests_run++; if (obs_addr[idx(35, 26)] !== 17'd191) begin tests_failed++; $display("FAIL tg_hold_last: got %h want %h", obs_addr[idx(35, 26)], 17'd191); end
        run_frame(-1, 1'b0, '0);
        tests_run++; if (obs_addr[idx(12, 9)] !== 17'd0) begin tests_failed++; $display("FAIL tg_1x_first: got %h want %h", obs_addr[idx(12, 9)], 17'd0); end
        tests_run++; if (obs_addr[idx(27, 20)] !== 17'd191) begin tests_failed++; $display("FAIL tg_1x_last: got %h want %h", obs_addr[idx(27, 20)], 17'd191); end
        tests_run++; if (obs_col[idx(4, 3)] !== 12'h0C7) begin tests_failed++; $display("FAIL tg_1x_border: got %h want %h", obs_col[idx(4, 3)], 12'h0C7); end
    endtask

    initial begin
        bus.pixel_x    = '0;
        bus.pixel_y    = '0;
        bus.scale_sel  = 1'b1;
        bus.fb_base    = '0;
        bus.border_rgb = 12'hFFE;
        test_reset();
        test_scale_2x();
        test_scale_1x();
        test_latency();
        test_double_buffer();
        test_scale_toggle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
